oven_stage: RTL and testbench

Tunnel-oven stage of the bakery plant model, directly downstream of the baking-pan conveyor. Filled pans from the conveyor are loaded through the door into a FIFO of oven slots. Each pan accumulates bake progress only while the oven is at or above baking temperature. Pans leave in arrival order on an unload command and are reported as raw, baked or burnt. Temperature, occupancy and per-pan progress are exposed as S_* states for inspection, like the rest of the plant.

---
 rtl/oven_stage_if.sv | 55 +++++
 rtl/oven_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_oven_stage.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oven_stage_if.sv
// oven_stage_if: command, sensor and status bundle of the tunnel-oven stage.
//
// Signals (direction as seen by the oven, i.e. the slave modport):
//   en              in   simulation step enable; 0 freezes the oven
//   X_heater        in   heater command
//   X_door          in   door open command
//   X_unload        in   remove the head pan
//   P_pan_in        in   full pan presented by the conveyor (level)
//   Y_pan_in_ready  out  door (registered) open and oven not full
//   Y_hot           out  oven at or above baking temperature
//   Y_head_baked    out  head pan has reached the bake threshold
//   Y_head_burnt    out  head pan has reached the burn threshold
//   Y_pan_out       out  one-cycle pulse: a pan left the oven
//   Y_pan_out_baked out  quality of the departing pan, valid with Y_pan_out
//   Y_pan_out_burnt out  quality of the departing pan, valid with Y_pan_out
//   Y_drop          out  one-cycle pulse: a presented pan was rejected
//   S_temp          out  oven temperature
//   S_pans          out  occupancy
//   S_head_progress out  head pan bake progress, 0 when empty
//   S_dropped       out  saturating rejected-pan count
//
// The master modport is the plant controller / conveyor side.
interface oven_stage_if;
  logic        en;
  logic        X_heater;
  logic        X_door;
  logic        X_unload;
  logic        P_pan_in;
  logic        Y_pan_in_ready;
  logic        Y_hot;
  logic        Y_head_baked;
  logic        Y_head_burnt;
  logic        Y_pan_out;
  logic        Y_pan_out_baked;
  logic        Y_pan_out_burnt;
  logic        Y_drop;
  logic [7:0]  S_temp;
  logic [3:0]  S_pans;
  logic [15:0] S_head_progress;
  logic [3:0]  S_dropped;

  modport master (
    output en, X_heater, X_door, X_unload, P_pan_in,
    input  Y_pan_in_ready, Y_hot, Y_head_baked, Y_head_burnt,
    input  Y_pan_out, Y_pan_out_baked, Y_pan_out_burnt, Y_drop,
    input  S_temp, S_pans, S_head_progress, S_dropped
  );

  modport slave (
    input  en, X_heater, X_door, X_unload, P_pan_in,
    output Y_pan_in_ready, Y_hot, Y_head_baked, Y_head_burnt,
    output Y_pan_out, Y_pan_out_baked, Y_pan_out_burnt, Y_drop,
    output S_temp, S_pans, S_head_progress, S_dropped
  );
endinterface

// File: rtl/oven_stage.sv
// oven_stage: tunnel-oven stage of the bakery plant model.
//
// Pans arriving from the baking-pan conveyor are loaded through the door into
// an in-order FIFO of SLOTS oven slots. Every occupied slot gains one unit of
// bake progress per enabled cycle while the oven is hot. Pans leave in arrival
// order on an unload command and are reported as baked and/or burnt.
//
// Ports:
//   clk  plant clock
//   rst  synchronous active-high reset, dominates en
//   bus  oven_stage_if.slave: commands (en, X_*, P_pan_in) in, Y_* / S_* out
//
// Configuration macro:
//   OVEN_BURN_EN  defined: burn threshold active, progress saturates at
//                 BAKE_CYCLES+BURN_CYCLES. Undefined: progress saturates at
//                 BAKE_CYCLES and both burnt flags are tied low.
//
// The FIFO is a shift register with the head at slot 0: a pop shifts every
// slot down by one, so the head is always prog_q[0] and vacated slots read 0.
module oven_stage #(
  parameter int unsigned SLOTS       = 4,
  parameter int unsigned BAKE_CYCLES = 200,
  parameter int unsigned BURN_CYCLES = 50,
  parameter int unsigned AMBIENT     = 20,
  parameter int unsigned TEMP_BAKE   = 180,
  parameter int unsigned TEMP_MAX    = 250,
  parameter int unsigned HEAT_STEP   = 2,
  parameter int unsigned COOL_STEP   = 1
) (
  input logic         clk,
  input logic         rst,
  oven_stage_if.slave bus
);

  localparam logic [3:0]  SlotsW   = 4'(SLOTS);
  localparam logic [15:0] BakeW    = 16'(BAKE_CYCLES);
`ifdef OVEN_BURN_EN
  localparam logic [15:0] BurnW    = 16'(BAKE_CYCLES + BURN_CYCLES);
  localparam logic [15:0] ProgMax  = BurnW;
`else
  localparam logic [15:0] ProgMax  = BakeW;

  // The burn threshold has no effect in this build.
  logic unused_burn_cycles;
  assign unused_burn_cycles = ^BURN_CYCLES;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]  temp_q, temp_d;
  logic [3:0]  pans_q, pans_d;
  logic [3:0]  dropped_q, dropped_d;
  logic        door_q;
  logic [15:0] prog_q   [SLOTS];
  logic [15:0] prog_d   [SLOTS];
  logic [15:0] prog_inc [SLOTS];

  logic        pan_out_q, pan_out_baked_q, pan_out_burnt_q, drop_q;

  // ---------------------------------------------------------------------------
  // Decode of this cycle's commands
  // ---------------------------------------------------------------------------
  logic       hot;
  logic       heat;
  logic       pop;
  logic       push;
  logic       drop;
  logic [3:0] tail_idx;
  logic       pop_baked;
  logic       pop_burnt;

  // Progress uses the pre-edge temperature, i.e. the Y_hot currently shown.
  assign hot  = temp_q >= 8'(TEMP_BAKE);
  assign heat = bus.X_heater && !bus.X_door;
  assign pop  = bus.X_unload && bus.X_door && (pans_q != 4'd0);
  // A same-edge pop frees a slot, so a full oven still accepts the push.
  assign push = bus.P_pan_in && bus.X_door && ((pans_q < SlotsW) || pop);
  assign drop = bus.P_pan_in && !push;
  // Slot written by a push, counted after any same-edge pop.
  assign tail_idx = pans_q - {3'b000, pop};

  // ---------------------------------------------------------------------------
  // Temperature: 9-bit arithmetic so neither limit can wrap before clamping
  // ---------------------------------------------------------------------------
  logic [8:0] temp_wide;
  logic [8:0] cool_step;

  always_comb begin
    temp_wide = {1'b0, temp_q};
    cool_step = bus.X_door ? 9'(2 * COOL_STEP) : 9'(COOL_STEP);
    temp_d    = temp_q;
    if (heat) begin
      temp_wide = {1'b0, temp_q} + 9'(HEAT_STEP);
      temp_d    = (temp_wide > 9'(TEMP_MAX)) ? 8'(TEMP_MAX) : temp_wide[7:0];
    end else begin
      if ({1'b0, temp_q} < (9'(AMBIENT) + cool_step)) begin
        temp_d = 8'(AMBIENT);
      end else begin
        temp_wide = {1'b0, temp_q} - cool_step;
        temp_d    = temp_wide[7:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Slot progress: increment, then shift on pop, then insert on push
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < int'(SLOTS); i++) begin
      prog_inc[i] = prog_q[i];
      if (hot && (4'(i) < pans_q) && (prog_q[i] < ProgMax)) begin
        prog_inc[i] = prog_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(SLOTS); i++) begin
      prog_d[i] = prog_inc[i];
    end
    if (pop) begin
      for (int i = 0; i < int'(SLOTS) - 1; i++) begin
        prog_d[i] = prog_inc[i + 1];
      end
      prog_d[SLOTS-1] = '0;
    end
    if (push) begin
      for (int i = 0; i < int'(SLOTS); i++) begin
        if (4'(i) == tail_idx) begin
          prog_d[i] = '0;
        end
      end
    end
  end

  // Quality of the departing pan includes this edge's increment.
  assign pop_baked = prog_inc[0] >= BakeW;
`ifdef OVEN_BURN_EN
  assign pop_burnt = prog_inc[0] >= BurnW;
`else
  assign pop_burnt = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Occupancy and reject counter
  // ---------------------------------------------------------------------------
  always_comb begin
    pans_d = pans_q;
    case ({push, pop})
      2'b10:   pans_d = pans_q + 4'd1;
      2'b01:   pans_d = pans_q - 4'd1;
      default: pans_d = pans_q;
    endcase
  end

  always_comb begin
    dropped_d = dropped_q;
    if (drop && (dropped_q != 4'hF)) begin
      dropped_d = dropped_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers: en gates all state; pulses clear whenever en is low
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      temp_q          <= 8'(AMBIENT);
      pans_q          <= '0;
      dropped_q       <= '0;
      door_q          <= 1'b0;
      pan_out_q       <= 1'b0;
      pan_out_baked_q <= 1'b0;
      pan_out_burnt_q <= 1'b0;
      drop_q          <= 1'b0;
      for (int i = 0; i < int'(SLOTS); i++) begin
        prog_q[i] <= '0;
      end
    end else begin
      pan_out_q       <= bus.en && pop;
      pan_out_baked_q <= bus.en && pop && pop_baked;
      pan_out_burnt_q <= bus.en && pop && pop_burnt;
      drop_q          <= bus.en && drop;
      if (bus.en) begin
        temp_q    <= temp_d;
        pans_q    <= pans_d;
        dropped_q <= dropped_d;
        door_q    <= bus.X_door;
        for (int i = 0; i < int'(SLOTS); i++) begin
          prog_q[i] <= prog_d[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: functions of registered state only
  // ---------------------------------------------------------------------------
  assign bus.Y_pan_in_ready  = door_q && (pans_q < SlotsW);
  assign bus.Y_hot           = hot;
  assign bus.Y_head_baked    = prog_q[0] >= BakeW;
`ifdef OVEN_BURN_EN
  assign bus.Y_head_burnt    = prog_q[0] >= BurnW;
`else
  assign bus.Y_head_burnt    = 1'b0;
`endif
  assign bus.Y_pan_out       = pan_out_q;
  assign bus.Y_pan_out_baked = pan_out_baked_q;
  assign bus.Y_pan_out_burnt = pan_out_burnt_q;
  assign bus.Y_drop          = drop_q;
  assign bus.S_temp          = temp_q;
  assign bus.S_pans          = pans_q;
  assign bus.S_head_progress = prog_q[0];
  assign bus.S_dropped       = dropped_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_pans_bounded : assert property (@(posedge clk) disable iff (rst) pans_q <= SlotsW);
  a_burnt_baked  : assert property (@(posedge clk) disable iff (rst)
                                    pan_out_burnt_q |-> pan_out_baked_q);
  a_temp_range   : assert property (@(posedge clk) disable iff (rst)
                                    (temp_q >= 8'(AMBIENT)) && (temp_q <= 8'(TEMP_MAX)));

endmodule

// File: tb/tb_oven_stage.sv
// Directed bench for oven_stage. The stimulus process queues the expected
// departing-pan quality and expected reject count before the edge that
// causes them; an independent monitor pops and compares on every Y_pan_out
// and Y_drop pulse. State outputs are checked directly after each edge.
module tb_oven_stage;

`ifdef OVEN_BURN_EN
  localparam logic        BurnOn  = 1'b1;
  localparam logic [15:0] SatProg = 16'd250;
`else
  localparam logic        BurnOn  = 1'b0;
  localparam logic [15:0] SatProg = 16'd200;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  oven_stage_if ovn ();

  oven_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (ovn)
  );

  int checks = 0;
  int errors = 0;

  // {baked, burnt} of each expected departing pan; expected S_dropped per drop.
  logic [1:0] out_exp_q  [$];
  logic [3:0] drop_exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic [1:0] mon_out;
  logic [3:0] mon_drop;

  always @(negedge clk) begin
    if (ovn.Y_pan_out === 1'b1) begin
      checks++;
      if (out_exp_q.size() == 0) begin
        errors++;
        $display("FAIL pan_out: unexpected pulse, baked=%0b burnt=%0b",
                 ovn.Y_pan_out_baked, ovn.Y_pan_out_burnt);
      end else begin
        mon_out = out_exp_q.pop_front();
        if ({ovn.Y_pan_out_baked, ovn.Y_pan_out_burnt} !== mon_out) begin
          errors++;
          $display("FAIL pan_out_quality: got baked=%0b burnt=%0b, expected baked=%0b burnt=%0b",
                   ovn.Y_pan_out_baked, ovn.Y_pan_out_burnt, mon_out[1], mon_out[0]);
        end
      end
    end
    if (ovn.Y_drop === 1'b1) begin
      checks++;
      if (drop_exp_q.size() == 0) begin
        errors++;
        $display("FAIL drop: unexpected pulse, S_dropped=%0d", ovn.S_dropped);
      end else begin
        mon_drop = drop_exp_q.pop_front();
        if (ovn.S_dropped !== mon_drop) begin
          errors++;
          $display("FAIL drop_count: got %0d, expected %0d", ovn.S_dropped, mon_drop);
        end
      end
    end
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    ovn.en       = 1'b1;
    ovn.X_heater = 1'b0;
    ovn.X_door   = 1'b0;
    ovn.X_unload = 1'b0;
    ovn.P_pan_in = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Reset, load one pan from a cold oven, then heat with the door closed.
  // The oven first reads hot after 80 heating edges, so edge 81 onward counts.
  task automatic load_and_heat(input int edges);
    do_reset();
    ovn.X_door   = 1'b1;
    ovn.P_pan_in = 1'b1;
    tick();
    ovn.P_pan_in = 1'b0;
    ovn.X_door   = 1'b0;
    ovn.X_heater = 1'b1;
    tick(edges);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    tick(2);

    // Reset state
    check("rst_temp", 32'(ovn.S_temp), 20);
    check("rst_pans", 32'(ovn.S_pans), 0);
    check("rst_dropped", 32'(ovn.S_dropped), 0);
    check("rst_head_progress", 32'(ovn.S_head_progress), 0);
    check("rst_ready", 32'(ovn.Y_pan_in_ready), 0);
    check("rst_hot", 32'(ovn.Y_hot), 0);
    check("rst_pan_out", 32'(ovn.Y_pan_out), 0);
    check("rst_drop", 32'(ovn.Y_drop), 0);
    rst = 1'b0;

    // Heating ramp from ambient, door closed
    ovn.X_heater = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      tick();
      if (c == 79) begin
        check("heat_c79_temp", 32'(ovn.S_temp), 178);
        check("heat_c79_hot", 32'(ovn.Y_hot), 0);
      end
      if (c == 80) begin
        check("heat_c80_temp", 32'(ovn.S_temp), 180);
        check("heat_c80_hot", 32'(ovn.Y_hot), 1);
      end
      if (c == 114) check("heat_c114_temp", 32'(ovn.S_temp), 248);
      if (c == 115) check("heat_c115_temp", 32'(ovn.S_temp), 250);
      if (c == 120) check("heat_sat_temp", 32'(ovn.S_temp), 250);
    end

    // Cooling: 1 per cycle closed, 2 per cycle open; en=0 freezes
    ovn.X_heater = 1'b0;
    tick();
    check("cool_closed", 32'(ovn.S_temp), 249);
    ovn.X_heater = 1'b1;
    ovn.X_door   = 1'b1;
    tick();
    check("cool_open_heater_on", 32'(ovn.S_temp), 247);
    check("ready_after_door", 32'(ovn.Y_pan_in_ready), 1);
    ovn.en = 1'b0;
    ovn.X_door = 1'b0;
    tick(3);
    check("freeze_temp", 32'(ovn.S_temp), 247);
    check("freeze_ready", 32'(ovn.Y_pan_in_ready), 1);
    ovn.en = 1'b1;
    tick(5);
    check("reheat_temp", 32'(ovn.S_temp), 250);

    // FIFO order: load pans every other edge while hot and cooling from 250
    ovn.X_heater = 1'b0;
    ovn.X_door   = 1'b1;
    for (int a = 1; a <= 7; a++) begin
      ovn.P_pan_in = (a % 2 == 1);
      tick();
    end
    check("fill_pans", 32'(ovn.S_pans), 4);
    check("fill_head", 32'(ovn.S_head_progress), 6);
    check("fill_ready", 32'(ovn.Y_pan_in_ready), 0);

    // Full oven: push and pop on the same edge
    ovn.P_pan_in = 1'b1;
    ovn.X_unload = 1'b1;
    out_exp_q.push_back(2'b00);
    tick();
    ovn.P_pan_in = 1'b0;
    check("swap_pans", 32'(ovn.S_pans), 4);
    check("swap_head", 32'(ovn.S_head_progress), 5);
    check("swap_dropped", 32'(ovn.S_dropped), 0);
    for (int u = 0; u < 4; u++) begin
      out_exp_q.push_back(2'b00);
      tick();
      check("drain_pans", 32'(ovn.S_pans), 32'(3 - u));
      case (u)
        0: check("drain_head0", 32'(ovn.S_head_progress), 4);
        1: check("drain_head1", 32'(ovn.S_head_progress), 3);
        2: check("drain_head2", 32'(ovn.S_head_progress), 3);
        default: check("drain_head3", 32'(ovn.S_head_progress), 0);
      endcase
    end
    // Unload on an empty oven is ignored
    tick();
    ovn.X_unload = 1'b0;
    check("empty_unload_pans", 32'(ovn.S_pans), 0);
    check("order_temp", 32'(ovn.S_temp), 224);

    // Overfill: 5 pushes into 4 slots, then a closed-door reject
    do_reset();
    ovn.X_door   = 1'b1;
    ovn.P_pan_in = 1'b1;
    tick(4);
    drop_exp_q.push_back(4'd1);
    tick();
    check("overfill_pans", 32'(ovn.S_pans), 4);
    check("overfill_dropped", 32'(ovn.S_dropped), 1);
    ovn.X_door = 1'b0;
    drop_exp_q.push_back(4'd2);
    tick();
    ovn.P_pan_in = 1'b0;
    check("closed_reject_dropped", 32'(ovn.S_dropped), 2);
    check("closed_ready", 32'(ovn.Y_pan_in_ready), 0);

    // Bake for a while, freeze, then reset while frozen
    ovn.X_heater = 1'b1;
    tick(100);
    check("midbake_temp", 32'(ovn.S_temp), 220);
    check("midbake_head", 32'(ovn.S_head_progress), 20);
    ovn.en       = 1'b0;
    ovn.X_door   = 1'b1;
    ovn.P_pan_in = 1'b1;
    ovn.X_unload = 1'b1;
    tick(3);
    check("frozen_head", 32'(ovn.S_head_progress), 20);
    check("frozen_pans", 32'(ovn.S_pans), 4);
    rst = 1'b1;
    tick();
    check("rst_en0_pans", 32'(ovn.S_pans), 0);
    check("rst_en0_temp", 32'(ovn.S_temp), 20);
    check("rst_en0_dropped", 32'(ovn.S_dropped), 0);
    check("rst_en0_head", 32'(ovn.S_head_progress), 0);
    rst = 1'b0;
    idle_inputs();

    // Bake to exactly the threshold, then unload
    load_and_heat(279);
    check("bake_199_head", 32'(ovn.S_head_progress), 199);
    check("bake_199_baked", 32'(ovn.Y_head_baked), 0);
    tick();
    check("bake_200_baked", 32'(ovn.Y_head_baked), 1);
    check("bake_200_burnt", 32'(ovn.Y_head_burnt), 0);
    ovn.X_heater = 1'b0;
    ovn.X_door   = 1'b1;
    ovn.X_unload = 1'b1;
    out_exp_q.push_back(2'b10);
    tick();
    idle_inputs();
    check("bake_out_pans", 32'(ovn.S_pans), 0);

    // Bake into the burn range, then unload
    load_and_heat(329);
    check("burn_249_head", 32'(ovn.S_head_progress), 32'(BurnOn ? 16'd249 : SatProg));
    check("burn_249_burnt", 32'(ovn.Y_head_burnt), 0);
    tick();
    check("burn_250_burnt", 32'(ovn.Y_head_burnt), 32'(BurnOn));
    tick(10);
    check("burn_sat_head", 32'(ovn.S_head_progress), 32'(SatProg));
    ovn.X_heater = 1'b0;
    ovn.X_door   = 1'b1;
    ovn.X_unload = 1'b1;
    out_exp_q.push_back({1'b1, BurnOn});
    tick();
    idle_inputs();
    check("burn_out_pans", 32'(ovn.S_pans), 0);

    tick(2);
    check("out_queue_drained", 32'(out_exp_q.size()), 0);
    check("drop_queue_drained", 32'(drop_exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
